// File: rtl/adder3_accum_if.sv
// ---------------------------------------------------------------------------
// adder3_accum_if
//   Bundles the two valid/ready channels of the adder3_accum frame accumulator
//   plus the frame-open pulse.
//
//   Handshake rule for both channels: a transfer happens on a rising clk edge
//   where valid && ready are both 1. The producer holds its payload stable
//   while valid is high. The consumer may raise or lower ready at any time.
//
//   Signals
//     start      producer -> accum  1-cycle pulse that opens a frame
//     in_valid   producer -> accum  in_data / in_last are valid
//     in_data    producer -> accum  WIDTH-bit unsigned operand
//     in_last    producer -> accum  final operand of the frame
//     in_ready   accum -> producer  accumulator takes a beat this cycle
//     out_valid  accum -> consumer  frame result valid
//     out_ready  consumer -> accum  consumer takes the result
//     out_sum    accum -> consumer  frame total (ACC_W bits)
//     out_count  accum -> consumer  beats accepted in the frame (CNT_W bits)
//     out_ovf    accum -> consumer  sticky carry-out of the accumulator MSB
//
//   Modports
//     slave  : the accumulator side
//     master : the producer/consumer side (the testbench)
// ---------------------------------------------------------------------------
interface adder3_accum_if #(
  parameter int WIDTH     = 3,
  parameter int ACC_W     = 8,
  parameter int MAX_BEATS = 64
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport slave (
    input  start, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output start, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/adder3_accum.sv
// ---------------------------------------------------------------------------
// adder3_accum
//   Frame accumulator. After a start pulse it sums unsigned WIDTH-bit operands
//   into an ACC_W-bit register (one operand per accepted beat) until a beat
//   carries in_last or MAX_BEATS beats have been taken, then presents the
//   total, beat count and sticky overflow flag until the consumer takes them.
//   The add path is a ripple chain of 1-bit full-adder cells, carry-in 0.
//
//   Ports
//     clk        rising-edge clock
//     areset     asynchronous, active-high reset
//     bus        adder3_accum_if.slave (start, in_* channel, out_* channel)
//     dbg_state  current FSM state: 0 IDLE, 1 RUN, 2 DONE
//
//   Build option
//     ADDER3_ACCUM_SAT_EN : when defined, the accumulator saturates to
//     all-ones on the first carry-out and stays there for the rest of the
//     frame. Undefined (default) the accumulator wraps modulo 2^ACC_W.
//     out_ovf behaves the same in both builds.
// ---------------------------------------------------------------------------

// 1-bit full-adder cell used to build the ripple chain.
module adder3_accum_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder3_accum #(
  parameter int WIDTH     = 3,
  parameter int ACC_W     = 8,
  parameter int MAX_BEATS = 64
) (
  input  logic                clk,
  input  logic                areset,
  adder3_accum_if.slave       bus,
  output logic [1:0]          dbg_state
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] sum;
  logic [ACC_W:0]   carry;
  logic             beat;
  logic             cnt_at_limit;

  // Ripple-carry add of the zero-extended operand onto the accumulator.
  assign addend   = ACC_W'(bus.in_data[WIDTH-1:0]);
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < ACC_W; i++) begin : g_fa
    adder3_accum_fa u_fa (
      .a  (acc_q[i]),
      .b  (addend[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign beat         = bus.in_valid && (state_q == RUN);
  // This beat would be the MAX_BEATS-th one of the frame.
  assign cnt_at_limit = (cnt_q == CNT_W'(MAX_BEATS - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (beat) begin
`ifdef ADDER3_ACCUM_SAT_EN
          // Once any carry has left the MSB in this frame, pin at all-ones.
          acc_d = (carry[ACC_W] || ovf_q) ? '1 : sum;
`else
          acc_d = sum;
`endif
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | carry[ACC_W];
          // in_last on the limit beat still terminates exactly once.
          if (bus.in_last || cnt_at_limit) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result registers are the accumulator itself; they only change in IDLE
  // (on start) and RUN (on beats), so they are frozen while DONE.
  assign bus.in_ready  = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_adder3_accum.sv
// ---------------------------------------------------------------------------
// tb_adder3_accum
//   Directed bench for adder3_accum. Instance a uses the default parameters;
//   instance b uses MAX_BEATS=4 for the beat-limit case. Inputs change 1 ns
//   after the rising edge and outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_adder3_accum;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef ADDER3_ACCUM_SAT_EN
  localparam int EXP_SUM_40X7 = 255;
`else
  localparam int EXP_SUM_40X7 = 24;
`endif

  logic       clk;
  logic       areset;
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;
  int         n_checks;
  int         n_errors;

  adder3_accum_if #(.WIDTH(3), .ACC_W(8), .MAX_BEATS(64)) bus_a ();
  adder3_accum_if #(.WIDTH(3), .ACC_W(8), .MAX_BEATS(4))  bus_b ();

  adder3_accum #(.WIDTH(3), .ACC_W(8), .MAX_BEATS(64)) dut_a (
    .clk       (clk),
    .areset    (areset),
    .bus       (bus_a),
    .dbg_state (dbg_a)
  );

  adder3_accum #(.WIDTH(3), .ACC_W(8), .MAX_BEATS(4)) dut_b (
    .clk       (clk),
    .areset    (areset),
    .bus       (bus_b),
    .dbg_state (dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
  endtask

  task automatic beat_a(input logic [2:0] d, input logic l);
    int n;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.in_last  = l;
    n = 0;
    while (!bus_a.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("beat_a_ready", {31'd0, bus_a.in_ready}, 32'd1);
    tick();
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  task automatic release_a();
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    areset   = 1'b1;
    bus_a.start = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    bus_a.in_last = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.start = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_data = '0;
    bus_b.in_last = 1'b0; bus_b.out_ready = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    tick();

    // reset state
    check("rst_state",     {30'd0, dbg_a}, S_IDLE);
    check("rst_in_ready",  {31'd0, bus_a.in_ready}, 0);
    check("rst_out_valid", {31'd0, bus_a.out_valid}, 0);
    check("rst_sum",       {24'd0, bus_a.out_sum}, 0);
    check("rst_count",     {25'd0, bus_a.out_count}, 0);
    check("rst_ovf",       {31'd0, bus_a.out_ovf}, 0);

    // 3 + 5 + 7
    start_a();
    check("t1_run", {30'd0, dbg_a}, S_RUN);
    beat_a(3'd3, 1'b0);
    check("t1_valid_b1", {31'd0, bus_a.out_valid}, 0);
    beat_a(3'd5, 1'b0);
    check("t1_valid_b2", {31'd0, bus_a.out_valid}, 0);
    beat_a(3'd7, 1'b1);
    check("t1_valid", {31'd0, bus_a.out_valid}, 1);
    check("t1_sum",   {24'd0, bus_a.out_sum}, 15);
    check("t1_count", {25'd0, bus_a.out_count}, 3);
    check("t1_ovf",   {31'd0, bus_a.out_ovf}, 0);
    check("t1_in_ready_done", {31'd0, bus_a.in_ready}, 0);

    // hold in DONE with out_ready low while start / in_valid toggle
    for (int i = 0; i < 10; i++) begin
      bus_a.start    = i[0];
      bus_a.in_valid = ~i[0];
      bus_a.in_data  = 3'd7;
      bus_a.in_last  = 1'b1;
      tick();
      check("t4_state", {30'd0, dbg_a}, S_DONE);
      check("t4_sum",   {24'd0, bus_a.out_sum}, 15);
      check("t4_count", {25'd0, bus_a.out_count}, 3);
    end
    bus_a.start = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
    check("t4_valid_held", {31'd0, bus_a.out_valid}, 1);
    release_a();
    check("t4_idle",       {30'd0, dbg_a}, S_IDLE);
    check("t4_valid_drop", {31'd0, bus_a.out_valid}, 0);
    check("t4_sum_kept",   {24'd0, bus_a.out_sum}, 15);
    check("t4_count_kept", {25'd0, bus_a.out_count}, 3);

    // 40 beats of 7 -> 280, overflows
    start_a();
    check("t2_sum_cleared", {24'd0, bus_a.out_sum}, 0);
    for (int i = 0; i < 40; i++) begin
      beat_a(3'd7, (i == 39));
    end
    check("t2_valid", {31'd0, bus_a.out_valid}, 1);
    check("t2_sum",   {24'd0, bus_a.out_sum}, EXP_SUM_40X7);
    check("t2_count", {25'd0, bus_a.out_count}, 40);
    check("t2_ovf",   {31'd0, bus_a.out_ovf}, 1);
    release_a();
    check("t2_ovf_kept_idle", {31'd0, bus_a.out_ovf}, 1);

    // MAX_BEATS=4 limit on instance b, in_last never set
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("t3_ready_pre", {31'd0, bus_b.in_ready}, 1);
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = 3'(k);
      tick();
    end
    check("t3_ready_low", {31'd0, bus_b.in_ready}, 0);
    check("t3_state",     {30'd0, dbg_b}, S_DONE);
    check("t3_sum",       {24'd0, bus_b.out_sum}, 10);
    check("t3_count",     {29'd0, bus_b.out_count}, 4);
    bus_b.in_data = 3'd5;
    tick();
    tick();
    tick();
    bus_b.in_valid = 1'b0;
    check("t3_sum_no5",   {24'd0, bus_b.out_sum}, 10);
    check("t3_count_no5", {29'd0, bus_b.out_count}, 4);
    bus_b.out_ready = 1'b1;
    tick();
    bus_b.out_ready = 1'b0;
    check("t3_idle", {30'd0, dbg_b}, S_IDLE);

    // asynchronous reset mid-frame
    start_a();
    beat_a(3'd2, 1'b0);
    beat_a(3'd2, 1'b0);
    check("t5_partial_sum", {24'd0, bus_a.out_sum}, 4);
    #2;
    areset = 1'b1;
    #1;
    check("t5_state",    {30'd0, dbg_a}, S_IDLE);
    check("t5_in_ready", {31'd0, bus_a.in_ready}, 0);
    check("t5_valid",    {31'd0, bus_a.out_valid}, 0);
    check("t5_sum",      {24'd0, bus_a.out_sum}, 0);
    check("t5_count",    {25'd0, bus_a.out_count}, 0);
    check("t5_ovf",      {31'd0, bus_a.out_ovf}, 0);
    tick();
    areset = 1'b0;
    tick();
    start_a();
    beat_a(3'd1, 1'b1);
    check("t5_after_sum",   {24'd0, bus_a.out_sum}, 1);
    check("t5_after_count", {25'd0, bus_a.out_count}, 1);
    release_a();

    // in_valid with start in IDLE, then gapped beats
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 3'd5;
    bus_a.start    = 1'b1;
    tick();
    bus_a.start    = 1'b0;
    bus_a.in_valid = 1'b0;
    check("t6_run",       {30'd0, dbg_a}, S_RUN);
    check("t6_count_idle", {25'd0, bus_a.out_count}, 0);
    check("t6_sum_idle",   {24'd0, bus_a.out_sum}, 0);
    begin
      logic [2:0] vals [3];
      vals[0] = 3'd6; vals[1] = 3'd0; vals[2] = 3'd1;
      for (int i = 0; i < 3; i++) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) tick();
        beat_a(vals[i], (i == 2));
      end
    end
    check("t6_valid", {31'd0, bus_a.out_valid}, 1);
    check("t6_sum",   {24'd0, bus_a.out_sum}, 7);
    check("t6_count", {25'd0, bus_a.out_count}, 3);
    release_a();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
